// File: rtl/fetch_queue_unit_if.sv
// Fetch queue bus: icache port, redirect input and the dequeue side toward IF/ID.
// The master side is the fetch queue itself.
interface fetch_queue_unit_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) ();
    logic                       icache_read;
    logic [XLEN-1:0]            icache_addr;
    logic [31:0]                icache_rdata;
    logic                       icache_resp;
    logic                       redirect;
    logic [XLEN-1:0]            redirect_pc;
    logic                       deq_ready;
    logic                       deq_valid;
    logic [XLEN-1:0]            deq_pc;
    logic [31:0]                deq_instr;
    logic [$clog2(DEPTH+1)-1:0] count;

    modport master (
        output icache_read, icache_addr, deq_valid, deq_pc, deq_instr, count,
        input  icache_rdata, icache_resp, redirect, redirect_pc, deq_ready
    );

    modport slave (
        input  icache_read, icache_addr, deq_valid, deq_pc, deq_instr, count,
        output icache_rdata, icache_resp, redirect, redirect_pc, deq_ready
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Fetch front end: owns the fetch PC and buffers {pc, instr} pairs for decode.
// Define FETCHQ_BYPASS_EN for a same-cycle path from icache to an empty queue head.
module fetch_queue_unit #(
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h00000060
) (
    input logic                clk,
    input logic                rst,
    fetch_queue_unit_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] stale_q, stale_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];

    logic resp_ok;
    logic bypass;
    logic deq_valid;
    logic enq;
    logic pop;

    assign resp_ok = (state_q == REQ) && bus.icache_resp && !bus.redirect;

`ifdef FETCHQ_BYPASS_EN
    assign bypass = resp_ok && (count_q == '0);
`else
    assign bypass = 1'b0;
`endif

    assign deq_valid = ((count_q != '0) || bypass) && !bus.redirect;
    assign pop       = deq_valid && bus.deq_ready && (count_q != '0);
    assign enq       = resp_ok && !(bypass && bus.deq_ready);

    assign bus.deq_valid   = deq_valid;
    assign bus.deq_pc      = bypass ? fetch_pc_q : pc_mem[rd_ptr_q];
    assign bus.deq_instr   = bypass ? bus.icache_rdata : instr_mem[rd_ptr_q];
    assign bus.count       = count_q;
    assign bus.icache_read = (state_q != IDLE);
    // A dropped request must keep presenting the address it was issued with
    assign bus.icache_addr = (state_q == DROP) ? stale_q : fetch_pc_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        stale_d    = stale_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d   = enq ? wr_ptr_q + AW'(1) : wr_ptr_q;
        count_d    = count_q + CW'(enq) - CW'(pop);
        if (resp_ok) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        unique case (state_q)
            IDLE: begin
                if (bus.redirect || (count_d < CW'(DEPTH))) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                stale_d = fetch_pc_q;
                if (bus.redirect) begin
                    state_d = bus.icache_resp ? REQ : DROP;
                end else if (bus.icache_resp) begin
                    state_d = (count_d < CW'(DEPTH)) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (bus.icache_resp) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc & ~XLEN'(3);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            stale_q    <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            stale_q    <= stale_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_ptr_q]    <= fetch_pc_q;
            instr_mem[wr_ptr_q] <= bus.icache_rdata;
        end
    end
endmodule
